xcvr_link_seq: RTL
==================

XCVR_LINK_SEQ -- requirements
Module: xcvr_link_seq

Interface
REQ-001 SHALL have parameter RST_HOLD_CYC, default 16: cycles phy_reset is held high per attempt (min 2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000000: cycles allowed in WAIT_READY before a retry.
REQ-003 SHALL have parameter STABLE_CYC, default 256: consecutive all-ready cycles required before link_up.
REQ-004 SHALL have parameter MAX_RETRY, default 7: retries allowed before FAULT (range 1..7).
REQ-005 SHALL have port clock, input, 1: the only clock; all logic is in this domain.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1: link bring-up request, level-sensitive.
REQ-008 SHALL have port tx_ready, input, 1: TX ready from the PHY reset controller.
REQ-009 SHALL have port rx_ready, input, 1: RX ready from the PHY reset controller.
REQ-010 SHALL have port rx_is_lockedtodata, input, 1: CDR lock from the transceiver.
REQ-011 SHALL have port phy_reset, output, 1: drives the reset input of the PHY reset controller.
REQ-012 SHALL have port link_up, output, 1: link is qualified and usable.
REQ-013 SHALL have port fault, output, 1: retries exhausted.
REQ-014 SHALL have port retry_cnt, output, 3: retries in the current bring-up.
REQ-015 SHALL have port link_drops, output, 8: saturating count of UP-to-retry events.
REQ-016 SHALL have port state, output, 3: current FSM state encoding.

Function
REQ-017 SHALL register all outputs; "all_ok" = tx_ready & rx_ready & rx_is_lockedtodata, after the optional synchroniser.
REQ-018 SHALL implement states: IDLE=0, RESET=1, WAIT_READY=2, STABLE=3, UP=4, FAULT=5.
REQ-019 IDLE: phy_reset=1; enable=1 -> RESET with the hold counter cleared.
REQ-020 RESET: phy_reset=1 for exactly RST_HOLD_CYC cycles, then -> WAIT_READY with the timer cleared.
REQ-021 WAIT_READY: phy_reset=0; all_ok -> STABLE; timer==TIMEOUT_CYC-1 with all_ok low -> retry.
REQ-022 If all_ok and timeout coincide, all_ok SHALL win.
REQ-023 STABLE: phy_reset=0; after STABLE_CYC consecutive all_ok cycles -> UP, so link_up rises STABLE_CYC+1 cycles after the first all_ok sample in WAIT_READY.
REQ-024 STABLE: any all_ok low -> retry.
REQ-025 UP: link_up=1; all_ok low -> retry, and link_drops increments (saturates at 255); retry_cnt clears on entry to UP.
REQ-026 Retry: retry_cnt==MAX_RETRY -> FAULT; else retry_cnt+1 and -> RESET.
REQ-027 FAULT: fault=1, phy_reset=1; it SHALL stay in FAULT until enable=0.
REQ-028 enable=0 in any state SHALL force IDLE on the next cycle and clear retry_cnt and fault; link_drops SHALL be retained.
REQ-029 link_up SHALL be 1 only in UP; fault SHALL be 1 only in FAULT.

Reset
REQ-030 reset=1 SHALL force, on the next clock edge: state=IDLE, phy_reset=1, link_up=0, fault=0, retry_cnt=0, link_drops=0, and all counters 0.
REQ-031 reset mid-operation, including while in UP, SHALL drop link_up in the same edge with no drop count.

Configuration
REQ-032 Macro XCVR_LINK_SEQ_INPUT_SYNC_EN defined: tx_ready, rx_ready and rx_is_lockedtodata SHALL pass through 2-flop synchronisers (reset to 0), adding 2 cycles to every input-to-response latency.
REQ-033 Macro XCVR_LINK_SEQ_INPUT_SYNC_EN undefined: the inputs SHALL be used directly, assumed synchronous to clock.

Structure
REQ-034 Package xcvr_link_seq_pkg SHALL hold the state enum typedef, state encodings and the retry counter width.
REQ-035 Sub-module xcvr_link_seq_sync (one 2-flop synchroniser bit) SHALL be instantiated 3x only when the macro is defined.

Verification (RST_HOLD_CYC=4, TIMEOUT_CYC=32, STABLE_CYC=8, MAX_RETRY=2, macro undefined)
REQ-036 Happy path: enable=1, all_ok high at WAIT_READY cycle 3 -> phy_reset high 4 cycles, link_up=1 exactly 9 cycles after the first all_ok, retry_cnt=0.
REQ-037 Timeout: all_ok never high -> three RESET pulses of 4 cycles, each 32 cycles apart, retry_cnt 0->1->2, then fault=1 with phy_reset=1.
REQ-038 Glitch: rx_is_lockedtodata low for 1 cycle at STABLE count 5 -> retry, retry_cnt=1, link_up stays 0.
REQ-039 Link drop: in UP, tx_ready low 1 cycle -> link_up=0 next cycle, link_drops=1, relink succeeds; 300 drops -> link_drops=255.
REQ-040 Abort/reset: enable=0 in FAULT -> IDLE, fault=0, retry_cnt=0; reset=1 in UP -> all outputs at reset values after 1 edge.

Source files
------------

// File: rtl/xcvr_link_seq_pkg.sv
// ============================================================================
// Module  : xcvr_link_seq_pkg
// Purpose : Shared types and widths for the transceiver link sequencer.
//           Holds the FSM state enum and its encodings, the retry counter
//           width and a small helper for sizing the shared cycle counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package xcvr_link_seq_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 3;
  localparam int DROPS_W = 8;

  // These encodings appear on the state output port, so they are fixed values.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_RESET      = 3'd1,
    ST_WAIT_READY = 3'd2,
    ST_STABLE     = 3'd3,
    ST_UP         = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  // Largest of three values. Sizes the one counter that is shared by the
  // hold, timeout and stability phases.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xcvr_link_seq_sync.sv
// ============================================================================
// Module  : xcvr_link_seq_sync
// Purpose : One-bit, two-flop synchroniser. Both flops reset to 0.
// Ports   : clock - destination clock
//           reset - synchronous active-high reset
//           d     - asynchronous input bit
//           q     - synchronised output bit (two cycles of latency)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xcvr_link_seq_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= 1'b0;
      q      <= 1'b0;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/xcvr_link_seq.sv
// ============================================================================
// Module  : xcvr_link_seq
// Purpose : Transceiver link bring-up sequencer. It pulses the PHY reset
//           controller and waits for TX/RX ready and CDR lock. It then
//           qualifies the link over a stability window and retries on
//           timeout or loss. After MAX_RETRY retries it reports a fault.
// Ports   : clock, reset        - single clock, synchronous active-high reset
//           enable              - level-sensitive bring-up request
//           tx_ready, rx_ready  - PHY reset controller status
//           rx_is_lockedtodata  - CDR lock
//           phy_reset           - reset to the PHY reset controller
//           link_up, fault      - link qualified / retries exhausted
//           retry_cnt[2:0]      - retries in the current bring-up
//           link_drops[7:0]     - saturating count of UP-to-retry events
//           state[2:0]          - current FSM state encoding
// Config  : XCVR_LINK_SEQ_INPUT_SYNC_EN - when defined, the three status
//           inputs pass through 2-flop synchronisers. This adds 2 cycles of
//           latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xcvr_link_seq
  import xcvr_link_seq_pkg::*;
#(
  parameter int RST_HOLD_CYC = 16,
  parameter int TIMEOUT_CYC  = 1000000,
  parameter int STABLE_CYC   = 256,
  parameter int MAX_RETRY    = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 tx_ready,
  input  logic                 rx_ready,
  input  logic                 rx_is_lockedtodata,
  output logic                 phy_reset,
  output logic                 link_up,
  output logic                 fault,
  output logic [RETRY_W-1:0]   retry_cnt,
  output logic [DROPS_W-1:0]   link_drops,
  output logic [STATE_W-1:0]   state
);

  localparam int CNT_MAX = max3(RST_HOLD_CYC, TIMEOUT_CYC, STABLE_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY);

  // --------------------------------------------------------------------------
  // Status inputs, optionally synchronised
  // --------------------------------------------------------------------------
  logic w_tx_ready;
  logic w_rx_ready;
  logic w_rx_locked;
  logic w_all_ok;

`ifdef XCVR_LINK_SEQ_INPUT_SYNC_EN
  xcvr_link_seq_sync u_sync_tx_ready (
    .clock (clock),
    .reset (reset),
    .d     (tx_ready),
    .q     (w_tx_ready)
  );

  xcvr_link_seq_sync u_sync_rx_ready (
    .clock (clock),
    .reset (reset),
    .d     (rx_ready),
    .q     (w_rx_ready)
  );

  xcvr_link_seq_sync u_sync_rx_locked (
    .clock (clock),
    .reset (reset),
    .d     (rx_is_lockedtodata),
    .q     (w_rx_locked)
  );
`else
  assign w_tx_ready  = tx_ready;
  assign w_rx_ready  = rx_ready;
  assign w_rx_locked = rx_is_lockedtodata;
`endif

  assign w_all_ok = w_tx_ready & w_rx_ready & w_rx_locked;

  // --------------------------------------------------------------------------
  // State and counters
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_d;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_d;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_d;
  logic [DROPS_W-1:0] r_drops;
  logic [DROPS_W-1:0] w_drops_d;
  logic               w_retry_req;
  logic               w_phy_reset_d;
  logic               w_link_up_d;
  logic               w_fault_d;

  // State register. The decoded outputs are registered from the next state,
  // so they change on the same edge as the state. This lets link_up drop on
  // the edge where reset is applied.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_drops   <= '0;
      phy_reset <= 1'b1;
      link_up   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_retry   <= w_retry_d;
      r_drops   <= w_drops_d;
      phy_reset <= w_phy_reset_d;
      link_up   <= w_link_up_d;
      fault     <= w_fault_d;
    end
  end

  // Next-state logic. The cycle counter defaults to 0. It only increments
  // while the FSM stays in a timed state, so every transition clears it.
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = '0;
    w_retry_d   = r_retry;
    w_drops_d   = r_drops;
    w_retry_req = 1'b0;

    if (!enable) begin
      w_state_d = ST_IDLE;
      w_retry_d = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_d = ST_RESET;
        end
        ST_RESET: begin
          if (r_cnt == HOLD_LAST) begin
            w_state_d = ST_WAIT_READY;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        ST_WAIT_READY: begin
          // all_ok is tested first, so it wins over a timeout in the same cycle.
          if (w_all_ok) begin
            w_state_d = ST_STABLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_retry_req = 1'b1;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!w_all_ok) begin
            w_retry_req = 1'b1;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_d = ST_UP;
            w_retry_d = '0;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        ST_UP: begin
          if (!w_all_ok) begin
            w_retry_req = 1'b1;
            if (r_drops != '1) begin
              w_drops_d = r_drops + 1'b1;
            end
          end
        end
        ST_FAULT: begin
          // Held here until enable is deasserted.
        end
        default: begin
          w_state_d = ST_IDLE;
        end
      endcase

      if (w_retry_req) begin
        if (r_retry == RETRY_LAST) begin
          w_state_d = ST_FAULT;
        end else begin
          w_retry_d = r_retry + 1'b1;
          w_state_d = ST_RESET;
        end
      end
    end
  end

  // Output decode of the next state.
  always_comb begin
    w_phy_reset_d = 1'b0;
    w_link_up_d   = 1'b0;
    w_fault_d     = 1'b0;
    case (w_state_d)
      ST_IDLE, ST_RESET: begin
        w_phy_reset_d = 1'b1;
      end
      ST_UP: begin
        w_link_up_d = 1'b1;
      end
      ST_FAULT: begin
        w_phy_reset_d = 1'b1;
        w_fault_d     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign retry_cnt  = r_retry;
  assign link_drops = r_drops;
  assign state      = r_state;

endmodule

`default_nettype wire
